// File: rtl/imm_encoder.sv
// Two-stage valid/ready pipeline that overlays a RISC-V immediate onto a base instruction
// and flags immediates that the chosen format cannot represent.
module imm_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        InValid,
    output logic        InReady,
    input  logic [2:0]  ImmSrc,
    input  logic [31:0] Imm,
    input  logic [31:0] BaseInstr,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] InstrOut,
    output logic        ImmErr,
    output logic [15:0] EncCount,
    output logic [15:0] ErrCount
);

    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_J = 3'd3,
        FMT_U = 3'd4
    } fmt_t;

    logic        s1_valid;
    logic [2:0]  s1_src;
    logic [31:0] s1_imm;
    logic [31:0] s1_base;

    logic        s1_advance;
    logic        s2_advance;
    logic [31:0] enc_instr;
    logic        enc_err;

    // Ready is derived from stage occupancy only, never from InValid.
    assign s2_advance = !OutValid || OutReady;
    assign s1_advance = !s1_valid || s2_advance;
    assign InReady    = s1_advance;

    always_comb begin
        enc_instr = s1_base;
        enc_err   = 1'b0;
        case (s1_src)
            FMT_I: begin
                enc_instr[31:20] = s1_imm[11:0];
                enc_err          = s1_imm[31:11] != {21{s1_imm[11]}};
            end
            FMT_S: begin
                enc_instr[31:25] = s1_imm[11:5];
                enc_instr[11:7]  = s1_imm[4:0];
                enc_err          = s1_imm[31:11] != {21{s1_imm[11]}};
            end
            FMT_B: begin
                enc_instr[31]    = s1_imm[12];
                enc_instr[7]     = s1_imm[11];
                enc_instr[30:25] = s1_imm[10:5];
                enc_instr[11:8]  = s1_imm[4:1];
                enc_err          = (s1_imm[31:12] != {20{s1_imm[12]}}) || s1_imm[0];
            end
            FMT_J: begin
                enc_instr[31]    = s1_imm[20];
                enc_instr[19:12] = s1_imm[19:12];
                enc_instr[20]    = s1_imm[11];
                enc_instr[30:21] = s1_imm[10:1];
                enc_err          = (s1_imm[31:20] != {12{s1_imm[20]}}) || s1_imm[0];
            end
            FMT_U: begin
                enc_instr[31:12] = s1_imm[31:12];
                enc_err          = s1_imm[11:0] != 12'd0;
            end
            default: begin
                enc_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_src   <= '0;
            s1_imm   <= '0;
            s1_base  <= '0;
            OutValid <= 1'b0;
            InstrOut <= '0;
            ImmErr   <= 1'b0;
            EncCount <= '0;
            ErrCount <= '0;
        end else begin
            if (s1_advance) begin
                s1_valid <= InValid;
                if (InValid) begin
                    s1_src  <= ImmSrc;
                    s1_imm  <= Imm;
                    s1_base <= BaseInstr;
                end
            end
            // Output data only moves when a new word lands, so it holds under backpressure.
            if (s2_advance) begin
                OutValid <= s1_valid;
                if (s1_valid) begin
                    InstrOut <= enc_instr;
                    ImmErr   <= enc_err;
                end
            end
            if (OutValid && OutReady) begin
                if (EncCount != '1) begin
                    EncCount <= EncCount + 16'd1;
                end
                if (ImmErr && ErrCount != '1) begin
                    ErrCount <= ErrCount + 16'd1;
                end
            end
        end
    end

endmodule
